spi_dma: RTL and testbench
==========================

// Module: spi_dma
// PURPOSE
//  Burst DMA sequencer feeding the SPI master's DMA port (dma_req/dma_din) and consuming its
//  start strobe and received byte (dout). Moves a block of 1..2^LEN_W bytes between a byte-wide
//  memory port and SPI without CPU involvement (SD sector transfers). dir=1: memory -> SPI (TX);
//  dir=0: SPI -> memory (RX, transmits fill byte 0xFF).
// PARAMETERS
//  ADDR_W     21  memory byte-address width; address wraps modulo 2^ADDR_W
//  LEN_W       9  length field width; length = len+1 bytes (1..512 at default)
//  BYTE_CLKS  17  clocks after the SPI start cycle until SPI dout is valid / SPI idle again
// PORTS
//  clk        in   1       system clock (same clock as SPI master)
//  rst_n      in   1       asynchronous reset, active low
//  go         in   1       1-clk start strobe; sampled only in IDLE
//  dir        in   1       0 = RX (SPI->mem), 1 = TX (mem->SPI); latched on go
//  addr       in   ADDR_W  start byte address; latched on go
//  len        in   LEN_W   byte count minus one; latched on go
//  abort      in   1       1-clk request to stop at next byte boundary
//  busy       out  1       high from cycle after accepted go until return to IDLE
//  done       out  1       1-clk pulse on normal completion
//  aborted    out  1       sticky: last transfer ended by abort; cleared by accepted go
//  mem_req    out  1       memory request, held until mem_ack
//  mem_we     out  1       1 = write (RX), 0 = read (TX)
//  mem_addr   out  ADDR_W  current byte address
//  mem_wdata  out  8       received byte for write
//  mem_rdata  in   8       read data, valid in mem_ack cycle
//  mem_ack    in   1       completes request in the cycle it is sampled high (may be same cycle)
//  spi_req    out  1       to SPI dma_req; high only in ISSUE
//  spi_dout   out  8       to SPI dma_din; TX byte, stable while spi_req high
//  spi_start  in   1       from SPI start (req && !busy), 1 clk
//  spi_din    in   8       from SPI dout (received byte)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busy, done, aborted, mem_req, mem_we, spi_req = 0;
//   mem_addr, mem_wdata, counters = 0; spi_dout = 8'hFF. Reset mid-transfer drops mem_req/spi_req
//   immediately; an in-flight SPI byte completes in the SPI block and is discarded.
//  States: IDLE, FETCH, ISSUE, SHIFT, STORE, NEXT.
//  IDLE: go=1 -> latch dir/addr/len, clear aborted; dir=1 -> FETCH, dir=0 -> ISSUE (spi_dout=FF).
//  FETCH: mem_req=1, mem_we=0; on mem_ack capture mem_rdata into spi_dout -> ISSUE.
//  ISSUE: spi_req=1; stay until spi_start=1 (waits out CPU-owned SPI bytes); in the start cycle
//   load timer=BYTE_CLKS-1 -> SHIFT.
//  SHIFT: timer counts down each clk; at timer==0 capture spi_din into mem_wdata;
//   dir=0 -> STORE, dir=1 -> NEXT. SHIFT always lasts exactly BYTE_CLKS clks (abort ignored).
//  STORE: mem_req=1, mem_we=1; on mem_ack -> NEXT.
//  NEXT (1 clk): mem_addr+1 (wrap); if abort pending -> IDLE, aborted=1, no done;
//   elif remaining==0 -> IDLE, done=1; else remaining-1 -> FETCH (TX) / ISSUE (RX, spi_dout=FF).
//  abort: a pulse in any non-IDLE state sets a pending flag acted on in NEXT; ignored in IDLE.
//   A byte whose SHIFT started is still stored (RX) before stopping.
//  go while busy is ignored. go and abort in same IDLE cycle: go wins, abort dropped.
//  Throughput, zero-wait mem_ack and no SPI contention: BYTE_CLKS+3 = 20 clks/byte both dirs;
//   len=N-1 gives busy high for 20*N clks; done coincident with last NEXT->IDLE edge.
//  Memory/SPI handshakes never overlap; mem_req deasserts the cycle after mem_ack.
// TESTING
//  TX len=2, addr=0x00100, mem bytes A5,3C,F0, ack same cycle -> spi_dout A5,3C,F0 at 3 starts,
//   starts 20 clks apart, done pulse once, busy 60 clks.
//  RX len=0 with SPI model returning 0x5A, mode=0 and mode=1 -> one write 0x5A @addr, dout=FF sent.
//  RX addr=0x1FFFFF len=1 -> writes at 0x1FFFFF then 0x000000 (wrap).
//  CPU holds SPI busy 30 clks while ISSUE -> spi_req stays high, byte sent after CPU byte; data ok.
//  abort mid-SHIFT of byte 2 of 512-byte RX -> byte 2 still written, then IDLE, aborted=1, no done.
//  mem_ack delayed 5 clks and rst_n pulsed low mid-STORE -> mem_req held stable, then all outputs
//   return to reset values asynchronously; next go runs cleanly.

Source files
------------

// File: rtl/spi_dma_if.sv
// spi_dma_if: control, memory-port and SPI DMA-port signals of the SPI burst DMA sequencer.
interface spi_dma_if #(
  parameter int ADDR_W = 21,
  parameter int LEN_W  = 9
);
  logic              go;
  logic              dir;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              abort;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              spi_req;
  logic [7:0]        spi_dout;
  logic              spi_start;
  logic [7:0]        spi_din;
  modport master (
    input  go, dir, addr, len, abort, mem_rdata, mem_ack, spi_start, spi_din,
    output busy, done, aborted, mem_req, mem_we, mem_addr, mem_wdata, spi_req, spi_dout
  );
  modport slave (
    output go, dir, addr, len, abort, mem_rdata, mem_ack, spi_start, spi_din,
    input  busy, done, aborted, mem_req, mem_we, mem_addr, mem_wdata, spi_req, spi_dout
  );
endinterface

// File: rtl/spi_dma.sv
// spi_dma: burst DMA sequencer moving len+1 bytes between a byte-wide memory port and the SPI
// master's DMA port; dir=1 reads memory and transmits, dir=0 transmits 0xFF and stores received bytes.
module spi_dma #(
  parameter int ADDR_W    = 21,
  parameter int LEN_W     = 9,
  parameter int BYTE_CLKS = 17
) (
  input logic        clk,
  input logic        rst_n,
  spi_dma_if.master  bus
);
  localparam int TW = $clog2(BYTE_CLKS + 1);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, SHIFT, STORE, NEXT} state_t;
  state_t            state_q, state_d;
  logic              dir_q, dir_d, abt_q, abt_d, aborted_q, aborted_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        wdata_q, wdata_d, dout_q, dout_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      abt_q     <= 1'b0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      timer_q   <= '0;
      wdata_q   <= '0;
      dout_q    <= 8'hFF;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      abt_q     <= abt_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      timer_q   <= timer_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
    end
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    timer_d   = timer_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    abt_d     = abt_q | (state_q != IDLE && bus.abort);
    case (state_q)
      IDLE: if (bus.go) begin
        dir_d     = bus.dir;
        addr_d    = bus.addr;
        rem_d     = bus.len;
        aborted_d = 1'b0;
        abt_d     = 1'b0;
        dout_d    = 8'hFF;
        state_d   = bus.dir ? FETCH : ISSUE;
      end
      FETCH: if (bus.mem_ack) begin
        dout_d  = bus.mem_rdata;
        state_d = ISSUE;
      end
      ISSUE: if (bus.spi_start) begin
        timer_d = TW'(BYTE_CLKS - 1);
        state_d = SHIFT;
      end
      SHIFT: if (timer_q == '0) begin
        wdata_d = bus.spi_din;
        state_d = dir_q ? NEXT : STORE;
      end else timer_d = timer_q - 1'b1;
      STORE: state_d = bus.mem_ack ? NEXT : STORE;
      NEXT: begin
        addr_d = addr_q + 1'b1;
        // abort wins over completion so a last-byte abort still reports aborted, not done
        if (abt_d) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          abt_d     = 1'b0;
        end else if (rem_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          rem_d   = rem_q - 1'b1;
          state_d = dir_q ? FETCH : ISSUE;
          dout_d  = dir_q ? dout_q : 8'hFF;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.mem_req   = state_q == FETCH || state_q == STORE;
  assign bus.mem_we    = state_q == STORE;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.spi_req   = state_q == ISSUE;
  assign bus.spi_dout  = dout_q;
endmodule

// File: tb/tb_spi_dma.sv
// tb_spi_dma: directed bench with a memory responder and a simple SPI-master timing model.
module tb_spi_dma;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_dma_if bus ();
  spi_dma dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errs = 0, nchk = 0;
  int cyc = 0, n_sent = 0, n_wr = 0, n_busy = 0, n_done = 0;
  int ack_dly = 0, wcnt = 0;
  logic       cpu_hold = 1'b0;
  logic [4:0] spi_cnt = '0;
  logic [7:0] rx_byte = 8'h5A;
  logic [7:0] rd_tab [4] = '{8'hA5, 8'h3C, 8'hF0, 8'h00};
  logic [7:0]  sent [64];
  int          t_start [64];
  logic [20:0] wr_a [64];
  logic [7:0]  wr_d [64];
  assign bus.spi_start = bus.spi_req && spi_cnt == 0 && !cpu_hold;
  assign bus.spi_din   = rx_byte;
  assign bus.mem_rdata = rd_tab[bus.mem_addr[1:0]];
  assign bus.mem_ack   = bus.mem_req && wcnt >= ack_dly;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    spi_cnt <= bus.spi_start ? 5'd17 : (spi_cnt != 0 ? spi_cnt - 5'd1 : 5'd0);
    wcnt    <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
    if (bus.spi_start) begin
      sent[n_sent & 63]    <= bus.spi_dout;
      t_start[n_sent & 63] <= cyc;
      n_sent               <= n_sent + 1;
    end
    if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
      wr_a[n_wr & 63] <= bus.mem_addr;
      wr_d[n_wr & 63] <= bus.mem_wdata;
      n_wr            <= n_wr + 1;
    end
    if (bus.busy) n_busy <= n_busy + 1;
    if (bus.done) n_done <= n_done + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input logic d, input logic [20:0] a, input logic [8:0] l);
    @(posedge clk) #1;
    bus.go = 1'b1; bus.dir = d; bus.addr = a; bus.len = l;
    @(posedge clk) #1;
    bus.go = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && bus.busy; i++) @(posedge clk) #1;
    chk("idle_timeout", {31'd0, bus.busy}, 0);
    @(posedge clk) #1;
  endtask
  int s, w, b, d;
  initial begin
    bus.go = 1'b0; bus.dir = 1'b0; bus.addr = '0; bus.len = '0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_aborted", {31'd0, bus.aborted}, 0);
    chk("rst_memreq", {31'd0, bus.mem_req}, 0);
    chk("rst_spireq", {31'd0, bus.spi_req}, 0);
    chk("rst_dout", {24'd0, bus.spi_dout}, 32'hFF);
    chk("rst_addr", {11'd0, bus.mem_addr}, 0);
    rst_n = 1'b1;
    // TX of three bytes with zero-wait memory
    s = n_sent; w = n_wr; b = n_busy; d = n_done;
    run(1'b1, 21'h00100, 9'd2);
    wait_idle(300);
    chk("tx_nsent", n_sent - s, 3);
    chk("tx_b0", {24'd0, sent[s & 63]}, 32'hA5);
    chk("tx_b1", {24'd0, sent[(s + 1) & 63]}, 32'h3C);
    chk("tx_b2", {24'd0, sent[(s + 2) & 63]}, 32'hF0);
    chk("tx_gap01", t_start[(s + 1) & 63] - t_start[s & 63], 20);
    chk("tx_gap12", t_start[(s + 2) & 63] - t_start[(s + 1) & 63], 20);
    chk("tx_done", n_done - d, 1);
    chk("tx_busy", n_busy - b, 60);
    chk("tx_nowr", n_wr - w, 0);
    // single-byte RX, twice
    rx_byte = 8'h5A;
    for (int m = 0; m < 2; m++) begin
      s = n_sent; w = n_wr; b = n_busy; d = n_done;
      run(1'b0, m == 0 ? 21'h00200 : 21'h0ABCD, 9'd0);
      wait_idle(100);
      chk("rx1_nwr", n_wr - w, 1);
      chk("rx1_addr", {11'd0, wr_a[w & 63]}, m == 0 ? 32'h200 : 32'hABCD);
      chk("rx1_data", {24'd0, wr_d[w & 63]}, 32'h5A);
      chk("rx1_fill", {24'd0, sent[s & 63]}, 32'hFF);
      chk("rx1_done", n_done - d, 1);
      chk("rx1_busy", n_busy - b, 20);
    end
    // address wrap at the top of memory
    rx_byte = 8'h77;
    w = n_wr;
    run(1'b0, 21'h1FFFFF, 9'd1);
    wait_idle(100);
    chk("wrap_nwr", n_wr - w, 2);
    chk("wrap_a0", {11'd0, wr_a[w & 63]}, 32'h1FFFFF);
    chk("wrap_a1", {11'd0, wr_a[(w + 1) & 63]}, 32'h0);
    chk("wrap_d1", {24'd0, wr_d[(w + 1) & 63]}, 32'h77);
    // CPU owns the SPI for 30 clocks while the DMA waits in ISSUE
    rx_byte = 8'h5A;
    s = n_sent; w = n_wr;
    cpu_hold = 1'b1;
    run(1'b0, 21'h00300, 9'd0);
    repeat (30) @(posedge clk) #1;
    chk("hold_req", {31'd0, bus.spi_req}, 1);
    chk("hold_nsent", n_sent - s, 0);
    cpu_hold = 1'b0;
    wait_idle(100);
    chk("hold_nwr", n_wr - w, 1);
    chk("hold_data", {24'd0, wr_d[w & 63]}, 32'h5A);
    chk("hold_addr", {11'd0, wr_a[w & 63]}, 32'h300);
    // abort during the SHIFT of the second byte of a 512-byte RX
    rx_byte = 8'hC3;
    s = n_sent; w = n_wr; d = n_done;
    run(1'b0, 21'h00400, 9'd511);
    for (int i = 0; i < 200 && n_sent - s < 2; i++) @(posedge clk) #1;
    repeat (5) @(posedge clk) #1;
    bus.abort = 1'b1;
    @(posedge clk) #1;
    bus.abort = 1'b0;
    wait_idle(100);
    chk("abt_nwr", n_wr - w, 2);
    chk("abt_addr1", {11'd0, wr_a[(w + 1) & 63]}, 32'h401);
    chk("abt_data1", {24'd0, wr_d[(w + 1) & 63]}, 32'hC3);
    chk("abt_flag", {31'd0, bus.aborted}, 1);
    chk("abt_nodone", n_done - d, 0);
    chk("abt_nsent", n_sent - s, 2);
    // delayed ack, then asynchronous reset in the middle of STORE
    rx_byte = 8'h5A;
    ack_dly = 5;
    w = n_wr;
    run(1'b0, 21'h00500, 9'd0);
    chk("go_clr_abt", {31'd0, bus.aborted}, 0);
    for (int i = 0; i < 100 && !(bus.mem_req && bus.mem_we); i++) @(posedge clk) #1;
    @(posedge clk) #1;
    chk("st_req_held", {31'd0, bus.mem_req && bus.mem_we}, 1);
    chk("st_addr", {11'd0, bus.mem_addr}, 32'h500);
    @(posedge clk) #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, bus.busy}, 0);
    chk("ar_memreq", {31'd0, bus.mem_req}, 0);
    chk("ar_dout", {24'd0, bus.spi_dout}, 32'hFF);
    chk("ar_addr", {11'd0, bus.mem_addr}, 0);
    chk("ar_nowr", n_wr - w, 0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    ack_dly = 0;
    repeat (2) @(posedge clk);
    w = n_wr; d = n_done;
    run(1'b0, 21'h00600, 9'd0);
    wait_idle(100);
    chk("post_nwr", n_wr - w, 1);
    chk("post_addr", {11'd0, wr_a[w & 63]}, 32'h600);
    chk("post_data", {24'd0, wr_d[w & 63]}, 32'h5A);
    chk("post_done", n_done - d, 1);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
